// File: rtl/reorder_buffer.sv
// Circular reorder buffer: in-order tag allocation, out-of-order completion writes,
// in-order retirement, plus one tag-indexed operand read port with write bypass.
module reorder_buffer #(
  parameter int ROBsize    = 32,
  parameter int ROBsizeLog = $clog2(ROBsize + 1),
  parameter int addrSize   = $clog2(ROBsize)
) (
  input  logic                  clk_i,
  input  logic                  reset_i,
  input  logic                  flush_i,
  input  logic                  alloc_valid_i,
  input  logic [4:0]            alloc_dest_i,
  output logic                  alloc_ready_o,
  output logic [ROBsizeLog-1:0] alloc_tag_o,
  input  logic                  ROBWriteEn_i,
  input  logic [addrSize:0]     ROBWriteAddr_i,
  input  logic [69:0]           ROBWriteData_i,
  input  logic [ROBsizeLog-1:0] rd_tag_i,
  output logic [64:0]           rd_val_o,
  output logic                  commit_valid_o,
  input  logic                  commit_ready_i,
  output logic [ROBsizeLog-1:0] commit_tag_o,
  output logic [4:0]            commit_dest_o,
  output logic [63:0]           commit_data_o,
  output logic [3:0]            commit_flags_o,
  output logic                  commit_flags_valid_o,
  output logic [ROBsizeLog-1:0] count_o
);

  localparam logic [ROBsizeLog-1:0] TAG_ONE   = ROBsizeLog'(1);
  localparam logic [ROBsizeLog-1:0] TAG_MAX   = ROBsizeLog'(ROBsize);
  localparam logic [addrSize:0]     WADDR_ONE = (addrSize + 1)'(1);
  localparam logic [addrSize:0]     WADDR_MAX = (addrSize + 1)'(ROBsize);

  // Tags are 1-based; storage is 0-based, so tag t lives in slot t-1.
  function automatic logic [addrSize-1:0] tag_idx(input logic [ROBsizeLog-1:0] tag);
    return addrSize'(tag - TAG_ONE);
  endfunction

  function automatic logic [ROBsizeLog-1:0] next_ptr(input logic [ROBsizeLog-1:0] ptr);
    return (ptr == TAG_MAX) ? TAG_ONE : ptr + TAG_ONE;
  endfunction

  logic [ROBsizeLog-1:0] head_q, head_d;
  logic [ROBsizeLog-1:0] tail_q, tail_d;
  logic [ROBsizeLog-1:0] count_q, count_d;
  logic [ROBsize-1:0]    busy_q, busy_d;
  logic [ROBsize-1:0]    dval_q, dval_d;
  logic [ROBsize-1:0]    fval_q, fval_d;
  logic [4:0]            dest_q  [ROBsize];
  logic [4:0]            dest_d  [ROBsize];
  logic [63:0]           data_q  [ROBsize];
  logic [63:0]           data_d  [ROBsize];
  logic [3:0]            flags_q [ROBsize];
  logic [3:0]            flags_d [ROBsize];

  logic [addrSize-1:0] head_idx;
  logic [addrSize-1:0] tail_idx;
  logic [addrSize-1:0] wr_idx;
  logic [addrSize-1:0] rd_idx;
  logic                wr_in_range;
  logic                wr_accept;
  logic                rd_in_range;
  logic                alloc_fire;
  logic                commit_fire;

  assign head_idx = tag_idx(head_q);
  assign tail_idx = tag_idx(tail_q);
  assign wr_idx   = addrSize'(ROBWriteAddr_i - WADDR_ONE);
  assign rd_idx   = tag_idx(rd_tag_i);

  assign wr_in_range = (ROBWriteAddr_i != '0) && (ROBWriteAddr_i <= WADDR_MAX);
  assign wr_accept   = ROBWriteEn_i && wr_in_range && busy_q[wr_idx];
  assign rd_in_range = (rd_tag_i != '0) && (rd_tag_i <= TAG_MAX);

  assign alloc_ready_o  = (count_q != TAG_MAX);
  assign alloc_tag_o    = tail_q;
  assign alloc_fire     = alloc_valid_i && alloc_ready_o;

  assign commit_valid_o       = (count_q != '0) && busy_q[head_idx] && dval_q[head_idx];
  assign commit_fire          = commit_valid_o && commit_ready_i;
  assign commit_tag_o         = head_q;
  assign commit_dest_o        = dest_q[head_idx];
  assign commit_data_o        = data_q[head_idx];
  assign commit_flags_o       = flags_q[head_idx];
  assign commit_flags_valid_o = fval_q[head_idx];
  assign count_o              = count_q;

  // Operand lookup; an accepted completion to the same tag is forwarded this cycle.
  always_comb begin
    rd_val_o = '0;
    if (rd_in_range) begin
      if (wr_accept && (wr_idx == rd_idx)) begin
        rd_val_o = {ROBWriteData_i[64], ROBWriteData_i[63:0]};
      end else if (busy_q[rd_idx]) begin
        rd_val_o = {dval_q[rd_idx], data_q[rd_idx]};
      end
    end
  end

  always_comb begin
    head_d  = head_q;
    tail_d  = tail_q;
    count_d = count_q;
    busy_d  = busy_q;
    dval_d  = dval_q;
    fval_d  = fval_q;
    dest_d  = dest_q;
    data_d  = data_q;
    flags_d = flags_q;
    if (flush_i) begin
      head_d  = TAG_ONE;
      tail_d  = TAG_ONE;
      count_d = '0;
      busy_d  = '0;
      dval_d  = '0;
      fval_d  = '0;
    end else begin
      if (alloc_fire) begin
        busy_d[tail_idx] = 1'b1;
        dval_d[tail_idx] = 1'b0;
        fval_d[tail_idx] = 1'b0;
        dest_d[tail_idx] = alloc_dest_i;
        tail_d           = next_ptr(tail_q);
      end
      if (wr_accept) begin
        data_d[wr_idx]  = ROBWriteData_i[63:0];
        dval_d[wr_idx]  = ROBWriteData_i[64];
        flags_d[wr_idx] = ROBWriteData_i[68:65];
        fval_d[wr_idx]  = ROBWriteData_i[69];
      end
      // Retirement is applied last so it wins over a completion to the retiring entry.
      if (commit_fire) begin
        busy_d[head_idx] = 1'b0;
        dval_d[head_idx] = 1'b0;
        fval_d[head_idx] = 1'b0;
        head_d           = next_ptr(head_q);
      end
      case ({alloc_fire, commit_fire})
        2'b10:   count_d = count_q + TAG_ONE;
        2'b01:   count_d = count_q - TAG_ONE;
        default: count_d = count_q;
      endcase
    end
  end

  always_ff @(posedge clk_i) begin
    if (reset_i) begin
      head_q  <= TAG_ONE;
      tail_q  <= TAG_ONE;
      count_q <= '0;
      busy_q  <= '0;
      dval_q  <= '0;
      fval_q  <= '0;
    end else begin
      head_q  <= head_d;
      tail_q  <= tail_d;
      count_q <= count_d;
      busy_q  <= busy_d;
      dval_q  <= dval_d;
      fval_q  <= fval_d;
    end
  end

  // Payload is only observable through busy/dval, so it needs no reset.
  always_ff @(posedge clk_i) begin
    dest_q  <= dest_d;
    data_q  <= data_d;
    flags_q <= flags_d;
  end

endmodule

// File: doc/reorder_buffer.md
Name: reorder_buffer

Overview:
- Circular reorder buffer that consumes the completion-stage write port, i.e. the write address, enable and 70-bit data.
- Allocates tags in program order at dispatch and accepts out-of-order result writes.
- Retires entries in order to the architectural commit interface.
- Provides one tag-indexed operand read port for dispatch/RS lookups.

Parameters:
- ROBsize, 32, number of entries; tags run 1..ROBsize, tag 0 = "no tag/invalid".
- ROBsizeLog, $clog2(ROBsize+1), tag width.
- addrSize, $clog2(ROBsize), write-address width is addrSize+1.

Ports:
- clk_i  in  1  clock
- reset_i  in  1  synchronous, active-high reset
- flush_i  in  1  discard all entries (mispredict/exception)
- alloc_valid_i  in  1  dispatch requests one entry
- alloc_dest_i  in  5  architectural destination register of the allocated instruction
- alloc_ready_o  out  1  entry available (not full)
- alloc_tag_o  out  ROBsizeLog  tag granted on this cycle's allocation (current tail)
- ROBWriteEn_i  in  1  completion write strobe
- ROBWriteAddr_i  in  addrSize+1  completion tag
- ROBWriteData_i  in  70  [63:0] data, [64] data valid, [68:65] flags, [69] flags valid
- rd_tag_i  in  ROBsizeLog  operand lookup tag
- rd_val_o  out  65  {valid, data[63:0]} for rd_tag_i
- commit_valid_o  out  1  head entry ready to retire
- commit_ready_i  in  1  retire accepted
- commit_tag_o  out  ROBsizeLog  head tag
- commit_dest_o  out  5  head destination register
- commit_data_o  out  64  head data
- commit_flags_o  out  4  head flags
- commit_flags_valid_o  out  1  head flags valid (write NZCV)
- count_o  out  ROBsizeLog  occupied entries

Behaviour:
- State per entry: busy, dest[4:0], data[63:0], dval, flags[3:0], fval.
- Pointer state: head, tail (range 1..ROBsize), count.
- Reset (and flush, identical effect): head=tail=1, count=0, all busy/dval/fval=0.
- Output values after reset: alloc_ready_o=1, alloc_tag_o=1, commit_valid_o=0, commit_tag_o=1, count_o=0, rd_val_o=0 for any tag.
- flush_i has priority over alloc, write and commit in the same cycle.
- Pointer wrap: pointer increments ROBsize -> 1, never to 0.
- Allocation:
  - alloc_ready_o = (count != ROBsize).
  - Fires when alloc_valid_i & alloc_ready_o.
  - Entry[tail]: busy=1, dest=alloc_dest_i, dval=fval=0. tail advances next cycle.
  - alloc_tag_o is combinational from the tail register; valid for the same cycle's allocation.
  - alloc_valid_i while full is ignored; no state change.
- Completion write:
  - Accepted when ROBWriteEn_i, 1 <= ROBWriteAddr_i <= ROBsize, and the entry is busy. Otherwise ignored: tag 0, out-of-range tags and stale/non-busy tags.
  - On accept: data <= [63:0], dval <= [64], flags <= [68:65], fval <= [69]. Update visible next cycle.
  - A rewrite of an already-valid entry overwrites it.
- Commit:
  - commit_valid_o = (count != 0) & busy[head] & dval[head]; all commit_* outputs are combinational from the head entry registers.
  - Fires when commit_valid_o & commit_ready_i: busy[head]=0, dval/fval=0, head advances.
  - A write to the head entry makes commit_valid_o rise the following cycle; there is no same-cycle write-to-commit bypass.
- Count:
  - Increments on alloc only; decrements on commit only; unchanged when both fire.
  - Alloc and commit in the same cycle are legal when full: commit frees, but alloc_ready_o reflects the registered count, so allocation is refused that cycle.
- Read port:
  - rd_val_o = {dval, data} of entry rd_tag_i when busy, else 0; rd_tag_i = 0 returns 0.
  - Same-cycle bypass: if an accepted completion write matches rd_tag_i, output {ROBWriteData_i[64], ROBWriteData_i[63:0]}.
- Allocation of a tag and a completion write to that same tag in the same cycle cannot occur legally. The entry is not busy, so the write is ignored.

Test Plan:
- Reset, then allocate 3 (dest 1,2,3) -> tags 1,2,3, count_o=3, commit_valid_o=0.
- Write tag 2 data 0xAA (bit64=1), then tag 1 data 0x55 with flags 4'b0100, bit69=1 -> commit tag1 (data 0x55, flags 4, flags_valid=1), then tag2 0xAA next cycle; tag3 is held.
- Allocate 32 with commit_ready_i=0 -> alloc_ready_o=0 at count 32; a 33rd request is ignored. Complete and retire tag 1 -> next alloc_tag_o=1 (wrap).
- ROBWriteEn_i with addr 0 and with a non-busy tag -> no state change; rd_val_o unchanged.
- Same cycle: write tag 5 value 0x1234 valid while rd_tag_i=5 -> rd_val_o={1,0x1234} that cycle.
- With 10 entries busy, assert flush_i concurrently with alloc and write -> next cycle count_o=0, alloc_tag_o=1, commit_valid_o=0. Mid-operation reset gives the same result.
